md_phase_sequencer: RTL and testbench

- Parametrised successor to the single-pipeline phase controller in the MD timestep loop.
- Sequences NUM_PHASES compute phases per timestep (e.g. force, filter, motion update) for a fixed, programmable number of timesteps.
- Toggles the particle-memory double buffer at each timestep boundary and reports progress and completion.
- Sits between memory-init logic (mem_set) and the per-phase pipeline controllers.

---
 rtl/md_ctrl_pkg.sv | 21 ++
 rtl/md_phase_sequencer_if.sv | 42 ++++
 rtl/md_phase_profiler.sv | 51 +++++
 rtl/md_phase_sequencer.sv | 141 ++++++++++++++
 tb/tb_md_phase_sequencer.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/md_ctrl_pkg.sv
// Shared definitions for the MD timestep phase sequencer: state encoding,
// default phase count and the names of the standard MD phases.
package md_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int MD_NUM_PHASES = 3;

  localparam int PH_FORCE  = 0;
  localparam int PH_FILTER = 1;
  localparam int PH_MOTION = 2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } seq_state_t;

endpackage

// File: rtl/md_phase_sequencer_if.sv
// Control/status bundle between the run host, the phase pipelines and the sequencer.
// MD_PHASE_PROFILE_EN adds the profiling counter outputs.
interface md_phase_sequencer_if
  import md_ctrl_pkg::*;
#(
    parameter int NUM_PHASES = MD_NUM_PHASES,
    parameter int STEP_W     = 32,
    parameter int PH_W       = 3
);
    logic                    mem_set;
    logic                    start;
    logic                    abort;
    logic [STEP_W-1:0]       target_steps;
    logic [NUM_PHASES-1:0]   phase_done;
    logic [NUM_PHASES-1:0]   phase_ready;
    logic [PH_W-1:0]         phase_idx;
    logic                    double_buffer;
    logic [STEP_W-1:0]       step_count;
    logic                    busy;
    logic                    sim_done;
`ifdef MD_PHASE_PROFILE_EN
    logic [NUM_PHASES*32-1:0] phase_cycles;
    logic [31:0]              last_step_cycles;
`endif

    modport slave (
        input  mem_set, start, abort, target_steps, phase_done,
`ifdef MD_PHASE_PROFILE_EN
        output phase_cycles, last_step_cycles,
`endif
        output phase_ready, phase_idx, double_buffer, step_count, busy, sim_done
    );

    modport master (
        output mem_set, start, abort, target_steps, phase_done,
`ifdef MD_PHASE_PROFILE_EN
        input  phase_cycles, last_step_cycles,
`endif
        input  phase_ready, phase_idx, double_buffer, step_count, busy, sim_done
    );

endinterface

// File: rtl/md_phase_profiler.sv
// Per-phase and per-timestep cycle counters with saturation; only built when
// MD_PHASE_PROFILE_EN is defined.
module md_phase_profiler #(
    parameter int NUM_PHASES = 3,
    parameter int PH_W       = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [PH_W-1:0]          phase_idx,
    input  logic                     active,
    input  logic                     step_strobe,
    input  logic                     clear,
    output logic [NUM_PHASES*32-1:0] phase_cycles,
    output logic [31:0]              last_step_cycles
);

    logic [31:0] cnt [NUM_PHASES];
    logic [31:0] step_acc;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_PHASES; i++) cnt[i] <= '0;
            step_acc         <= '0;
            last_step_cycles <= '0;
        end else if (clear) begin
            for (int i = 0; i < NUM_PHASES; i++) cnt[i] <= '0;
            step_acc         <= '0;
            last_step_cycles <= '0;
        end else if (active) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                if (phase_idx == PH_W'(i)) cnt[i] <= sat_inc(cnt[i]);
            end
            // The strobe cycle itself belongs to the step being closed.
            if (step_strobe) begin
                last_step_cycles <= sat_inc(step_acc);
                step_acc         <= '0;
            end else begin
                step_acc <= sat_inc(step_acc);
            end
        end
    end

    for (genvar g = 0; g < NUM_PHASES; g++) begin : g_flat
        assign phase_cycles[g*32 +: 32] = cnt[g];
    end

endmodule

// File: rtl/md_phase_sequencer.sv
// Sequences NUM_PHASES compute phases per MD timestep for a programmed step count,
// toggling the particle double buffer per step. Optional MD_PHASE_PROFILE_EN profiling.
module md_phase_sequencer
    import md_ctrl_pkg::*;
#(
    parameter int NUM_PHASES = MD_NUM_PHASES,
    parameter int STEP_W     = 32,
    parameter int PH_W       = 3
) (
    input  logic                clk,
    input  logic                reset_n,
    md_phase_sequencer_if.slave bus
);

    localparam logic [PH_W-1:0]       LAST_IDX = PH_W'(NUM_PHASES - 1);
    localparam logic [NUM_PHASES-1:0] FIRST_RDY = NUM_PHASES'(1);

    seq_state_t              state, state_nxt;
    logic [PH_W-1:0]         idx_q, idx_nxt;
    logic [NUM_PHASES-1:0]   ready_q, ready_nxt;
    logic                    db_q, db_nxt;
    logic [STEP_W-1:0]       step_q, step_nxt, step_inc;
    logic [STEP_W-1:0]       target_q, target_nxt;
    logic                    busy_q, done_q;
    logic                    accept, adv, last;

    assign accept   = bus.start && bus.mem_set && (state != S_RUN);
    // ready_q is one-hot of idx_q in RUN, so masking selects the active done bit.
    assign adv      = (state == S_RUN) && bus.mem_set && |(bus.phase_done & ready_q);
    assign last     = (idx_q == LAST_IDX);
    assign step_inc = step_q + STEP_W'(1);

    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx_q;
        ready_nxt  = ready_q;
        db_nxt     = db_q;
        step_nxt   = step_q;
        target_nxt = target_q;
        if (bus.abort) begin
            state_nxt = S_IDLE;
            idx_nxt   = PH_W'(PH_FORCE);
            ready_nxt = '0;
            step_nxt  = '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (accept) begin
                        target_nxt = bus.target_steps;
                        step_nxt   = '0;
                        idx_nxt    = PH_W'(PH_FORCE);
                        if (bus.target_steps == '0) begin
                            state_nxt = S_DONE;
                            ready_nxt = '0;
                        end else begin
                            state_nxt = S_RUN;
                            ready_nxt = FIRST_RDY;
                        end
                    end
                end
                S_RUN: begin
                    if (adv) begin
                        if (last) begin
                            db_nxt   = ~db_q;
                            step_nxt = step_inc;
                            idx_nxt  = PH_W'(PH_FORCE);
                            if (step_inc == target_q) begin
                                state_nxt = S_DONE;
                                ready_nxt = '0;
                            end else begin
                                ready_nxt = FIRST_RDY;
                            end
                        end else begin
                            idx_nxt   = idx_q + PH_W'(1);
                            ready_nxt = ready_q << 1;
                        end
                    end
                end
                default: begin
                    state_nxt = S_IDLE;
                    idx_nxt   = '0;
                    ready_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            idx_q   <= '0;
            ready_q <= '0;
            db_q    <= 1'b0;
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            idx_q   <= idx_nxt;
            ready_q <= ready_nxt;
            db_q    <= db_nxt;
            step_q  <= step_nxt;
            busy_q  <= (state_nxt == S_RUN);
            done_q  <= (state_nxt == S_DONE);
        end
    end

    // Target is pure data, only meaningful after an accepted start.
    always_ff @(posedge clk) begin
        target_q <= target_nxt;
    end

    assign bus.phase_ready   = ready_q;
    assign bus.phase_idx     = idx_q;
    assign bus.double_buffer = db_q;
    assign bus.step_count    = step_q;
    assign bus.busy          = busy_q;
    assign bus.sim_done      = done_q;

`ifdef MD_PHASE_PROFILE_EN
    logic prof_active, prof_strobe, prof_clear;
    assign prof_active = (state == S_RUN) && bus.mem_set && !bus.abort;
    assign prof_strobe = adv && last && !bus.abort;
    assign prof_clear  = bus.abort || accept;

    md_phase_profiler #(
        .NUM_PHASES (NUM_PHASES),
        .PH_W       (PH_W)
    ) u_profiler (
        .clk              (clk),
        .reset_n          (reset_n),
        .phase_idx        (idx_q),
        .active           (prof_active),
        .step_strobe      (prof_strobe),
        .clear            (prof_clear),
        .phase_cycles     (bus.phase_cycles),
        .last_step_cycles (bus.last_step_cycles)
    );
`endif

endmodule

// File: tb/tb_md_phase_sequencer.sv
// Directed self-checking bench for md_phase_sequencer (3 phases); profiling
// checks are compiled in when MD_PHASE_PROFILE_EN is defined.
module tb_md_phase_sequencer;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    md_phase_sequencer_if #(.NUM_PHASES(3), .STEP_W(32), .PH_W(3)) bus ();

    md_phase_sequencer #(.NUM_PHASES(3), .STEP_W(32), .PH_W(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] tgt);
        bus.target_steps = tgt;
        bus.start        = 1'b1;
        tick();
        bus.start        = 1'b0;
    endtask

    task automatic pulse_abort();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
    endtask

    task automatic chk_idle_outputs(input string tag, input logic db);
        chk({tag, "_ready"}, 32'(bus.phase_ready), 32'h0);
        chk({tag, "_idx"},   32'(bus.phase_idx), 32'h0);
        chk({tag, "_db"},    32'(bus.double_buffer), 32'(db));
        chk({tag, "_step"},  bus.step_count, 32'h0);
        chk({tag, "_busy"},  32'(bus.busy), 32'h0);
        chk({tag, "_done"},  32'(bus.sim_done), 32'h0);
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset_n          = 1'b0;
        bus.mem_set      = 1'b0;
        bus.start        = 1'b0;
        bus.abort        = 1'b0;
        bus.target_steps = '0;
        bus.phase_done   = '0;
        #3;
        chk_idle_outputs("reset", 1'b0);
        tick();
        reset_n = 1'b1;
        tick();
        chk_idle_outputs("post_reset", 1'b0);

        // Start ignored without mem_set, and not queued.
        bus.mem_set = 1'b0;
        do_start(32'd2);
        chk("nomem_busy", 32'(bus.busy), 32'h0);
        bus.mem_set = 1'b1;
        tick();
        chk("nomem_queue_busy", 32'(bus.busy), 32'h0);

        // Two timesteps, done pulsed on the third cycle of each phase.
        do_start(32'd2);
        for (int s = 0; s < 2; s++) begin
            for (int p = 0; p < 3; p++) begin
                chk($sformatf("seq_ready_s%0d_p%0d", s, p), 32'(bus.phase_ready), 32'(1) << p);
                chk($sformatf("seq_idx_s%0d_p%0d", s, p), 32'(bus.phase_idx), 32'(p));
                chk($sformatf("seq_step_s%0d_p%0d", s, p), bus.step_count, 32'(s));
                chk($sformatf("seq_db_s%0d_p%0d", s, p), 32'(bus.double_buffer), 32'(s % 2));
                chk($sformatf("seq_busy_s%0d_p%0d", s, p), 32'(bus.busy), 32'h1);
                repeat (2) begin
                    tick();
                    chk($sformatf("seq_hold_s%0d_p%0d", s, p), 32'(bus.phase_ready), 32'(1) << p);
                end
                bus.phase_done = 3'(1 << p);
                tick();
                bus.phase_done = '0;
            end
        end
        chk("seq_end_done",  32'(bus.sim_done), 32'h1);
        chk("seq_end_busy",  32'(bus.busy), 32'h0);
        chk("seq_end_ready", 32'(bus.phase_ready), 32'h0);
        chk("seq_end_step",  bus.step_count, 32'd2);
        chk("seq_end_db",    32'(bus.double_buffer), 32'h0);
        tick();
        chk("seq_hold_step", bus.step_count, 32'd2);
        chk("seq_hold_done", 32'(bus.sim_done), 32'h1);

        // Zero target from IDLE goes straight to DONE.
        pulse_abort();
        chk_idle_outputs("abort_done", 1'b0);
        do_start(32'd0);
        chk("zero_done",  32'(bus.sim_done), 32'h1);
        chk("zero_busy",  32'(bus.busy), 32'h0);
        chk("zero_step",  bus.step_count, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("zero_ready", 32'(bus.phase_ready), 32'h0);
            tick();
        end

        // Freeze while mem_set is low in phase 1, done held high.
        do_start(32'd5);
        chk("frz_ready0", 32'(bus.phase_ready), 32'h1);
        bus.phase_done = 3'b001;
        tick();
        chk("frz_ready1", 32'(bus.phase_ready), 32'h2);
        bus.mem_set    = 1'b0;
        bus.phase_done = 3'b010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("frz_hold_%0d", i), 32'(bus.phase_ready), 32'h2);
            chk($sformatf("frz_idx_%0d", i), 32'(bus.phase_idx), 32'h1);
        end
        bus.mem_set = 1'b1;
        tick();
        bus.phase_done = '0;
        chk("frz_resume", 32'(bus.phase_ready), 32'h4);
        chk("frz_resume_idx", 32'(bus.phase_idx), 32'h2);
        pulse_abort();
        chk_idle_outputs("frz_abort", 1'b0);

        // All-ones done: one advance per cycle, step every 3 cycles.
        do_start(32'd3);
        bus.phase_done = 3'b111;
        for (int c = 1; c <= 9; c++) begin
            tick();
            if (c < 9) begin
                chk($sformatf("ones_ready_%0d", c), 32'(bus.phase_ready), 32'(1) << (c % 3));
                chk($sformatf("ones_step_%0d", c), bus.step_count, 32'(c / 3));
                chk($sformatf("ones_db_%0d", c), 32'(bus.double_buffer), 32'((c / 3) % 2));
            end else begin
                chk("ones_done",  32'(bus.sim_done), 32'h1);
                chk("ones_ready", 32'(bus.phase_ready), 32'h0);
                chk("ones_step",  bus.step_count, 32'd3);
                chk("ones_db",    32'(bus.double_buffer), 32'h1);
            end
        end
        bus.phase_done = '0;

        // Abort coincident with last-phase done: no toggle, no increment.
        do_start(32'd3);
        chk("ab_restart_step", bus.step_count, 32'h0);
        chk("ab_restart_db",   32'(bus.double_buffer), 32'h1);
        bus.phase_done = 3'b001;
        tick();
        bus.phase_done = 3'b010;
        tick();
        chk("ab_ready_last", 32'(bus.phase_ready), 32'h4);
        bus.phase_done = 3'b100;
        bus.abort      = 1'b1;
        bus.start      = 1'b1;
        tick();
        bus.abort      = 1'b0;
        bus.start      = 1'b0;
        bus.phase_done = '0;
        chk_idle_outputs("ab_last", 1'b1);
        do_start(32'd1);
        bus.phase_done = 3'b111;
        repeat (3) tick();
        bus.phase_done = '0;
        chk("ab_one_done", 32'(bus.sim_done), 32'h1);
        chk("ab_one_step", bus.step_count, 32'h1);
        chk("ab_one_db",   32'(bus.double_buffer), 32'h0);

        // Async reset mid-run after one step has toggled the buffer.
        do_start(32'd2);
        bus.phase_done = 3'b111;
        repeat (4) tick();
        bus.phase_done = '0;
        chk("rst_pre_db",   32'(bus.double_buffer), 32'h1);
        chk("rst_pre_step", bus.step_count, 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle_outputs("rst_mid", 1'b0);
        tick();
        reset_n = 1'b1;
        tick();

`ifdef MD_PHASE_PROFILE_EN
        // Phase durations 4, 7 and 2 cycles.
        do_start(32'd1);
        repeat (3) tick();
        bus.phase_done = 3'b001;
        tick();
        bus.phase_done = '0;
        repeat (6) tick();
        bus.phase_done = 3'b010;
        tick();
        bus.phase_done = '0;
        tick();
        bus.phase_done = 3'b100;
        tick();
        bus.phase_done = '0;
        chk("prof_done", 32'(bus.sim_done), 32'h1);
        chk("prof_ph0",  bus.phase_cycles[31:0], 32'd4);
        chk("prof_ph1",  bus.phase_cycles[63:32], 32'd7);
        chk("prof_ph2",  bus.phase_cycles[95:64], 32'd2);
        chk("prof_last", bus.last_step_cycles, 32'd13);
        pulse_abort();
        chk("prof_clr",  bus.phase_cycles[31:0], 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
